// File: rtl/hm_pkg.sv
// Shared types and helpers for the hashing-result scheduler.
// Result layout: hash in the upper 256 bits, nonce in the low 32.
package hm_pkg;

    typedef enum logic {IDLE, SEND} hm_sched_state_t;

    localparam int HM_RESULT_WORDS = 9;
    localparam int HM_RESULT_BITS  = 288;

    typedef struct packed {
        logic [255:0] hash;
        logic [31:0]  nonce;
    } hm_result_t;

    function automatic logic [31:0] byte_swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/hm_result_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner on update.
// Latency: grant same cycle as req; pointer moves on the update edge.
// Backpressure: none; caller decides when a grant is consumed via update.
module rr_arbiter #(
    parameter int NUM_CORES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CORES-1:0]         req,
    input  logic                         update,
    output logic [NUM_CORES-1:0]         grant,
    output logic [$clog2(NUM_CORES)-1:0] grant_idx
);
    localparam int IW = $clog2(NUM_CORES);

    logic [IW-1:0] ptr;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    // Scan from ptr upward, wrapping, and take the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_CORES))
                sum = sum - (IW+1)'(NUM_CORES);
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (update)
            ptr <= (grant_idx == IW'(NUM_CORES-1)) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/hm_result_scheduler.sv
// Captures one core result via round-robin, halts cores, streams 9 byte-swapped words.
// Latency: ack, busy and word 0 appear the cycle after core_valid in IDLE.
// Backpressure: out_word/out_last hold while out_valid && !out_ready.
module hm_result_scheduler
    import hm_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_valid,
    input  logic [NUM_CORES-1:0][255:0] core_hash,
    input  logic [NUM_CORES-1:0][31:0]  core_nonce,
    output logic [NUM_CORES-1:0]        core_ack,
    input  logic                        new_job,
    output logic                        halt_cores,
    output logic [31:0]                 out_word,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy
);
    localparam int WORDS = HM_RESULT_WORDS;
    localparam int IW    = $clog2(NUM_CORES);

    hm_sched_state_t                state;
    logic [3:0]                     k;
    hm_result_t                     result;
    logic [WORDS-1:0][31:0]         result_words;
    logic [NUM_CORES-1:0]           grant;
    logic [IW-1:0]                  grant_idx;
    logic                           capture;

    assign capture = (state == IDLE) && (|core_valid);

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (core_valid),
        .update    (capture),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Word 0 is the top 32 bits of the hash, so index from the MSB end.
    assign result_words = result;
    assign out_word     = byte_swap32(result_words[4'(WORDS-1) - k]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            result     <= '0;
            core_ack   <= '0;
            halt_cores <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            core_ack <= '0;
            // A capture on the same edge as new_job keeps the cores halted.
            if (capture)
                halt_cores <= 1'b1;
            else if (new_job)
                halt_cores <= 1'b0;

            case (state)
                IDLE: begin
                    if (capture) begin
                        result    <= {core_hash[grant_idx], core_nonce[grant_idx]};
                        k         <= '0;
                        core_ack  <= grant;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            k         <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            k        <= k + 1'b1;
                            out_last <= (k == 4'(WORDS-2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hm_result_scheduler.sv
// Scoreboard bench for hm_result_scheduler: expected words queued at capture, checked on each handshake.
module tb_hm_result_scheduler;
    import hm_pkg::*;

    localparam int NC = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NC-1:0]        core_valid;
    logic [NC-1:0][255:0] core_hash;
    logic [NC-1:0][31:0]  core_nonce;
    logic [NC-1:0]        core_ack;
    logic                 new_job;
    logic                 halt_cores;
    logic [31:0]          out_word;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;

    always #5 clk = ~clk;

    hm_result_scheduler #(.NUM_CORES(NC)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_valid (core_valid),
        .core_hash  (core_hash),
        .core_nonce (core_nonce),
        .core_ack   (core_ack),
        .new_job    (new_job),
        .halt_cores (halt_cores),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          acc_cnt = 0;
    logic [32:0] sb[$];
    logic [32:0] sb_e;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word;
    logic        prev_last;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sw32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    task automatic push_result(input int c);
        logic [31:0] w;
        for (int j = 0; j < 9; j++) begin
            if (j < 8) w = core_hash[c][255-32*j -: 32];
            else       w = core_nonce[c];
            sb.push_back({(j == 8), sw32(w)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect core c to win the next edge; its words go on the scoreboard first.
    task automatic capture(input int c);
        push_result(c);
        step();
        check_eq($sformatf("ack_core%0d", c), core_ack, 64'(1 << c));
        core_valid[c] = 1'b0;
    endtask

    task automatic wait_idle(input bit bp);
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            if (bp) out_ready = pat[i % 4];
            step();
        end
        if (busy) check_eq("idle_timeout", busy, 0);
        out_ready = 1'b1;
    endtask

    // Handshake monitor: scoreboard compare plus hold-stability during stalls.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check_eq("stall_word", out_word, prev_word);
                check_eq("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got word %0h with nothing expected", out_word);
                end else begin
                    sb_e = sb.pop_front();
                    check_eq("word", out_word, sb_e[31:0]);
                    check_eq("last", out_last, sb_e[32]);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = out_word;
            prev_last  = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        logic ack_seen;

        core_hash[2]  = 256'h00112233445566778899AABBCCDDEEFF00112233445566778899AABBCCDDEEFF;
        core_nonce[2] = 32'h12345678;
        for (int c = 0; c < NC; c++) begin
            if (c != 2) begin
                for (int j = 0; j < 8; j++) core_hash[c][j*32 +: 32] = $urandom;
                core_nonce[c] = $urandom;
            end
        end
        rst = 1'b1; core_valid = '0; new_job = 1'b0; out_ready = 1'b1;
        step(); step();

        check_eq("rst_ack",   core_ack, 0);
        check_eq("rst_halt",  halt_cores, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_last",  out_last, 0);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_word",  out_word, 0);
        rst = 1'b0;
        step();

        // Single core 2
        core_valid = 4'b0100;
        capture(2);
        check_eq("single_busy",  busy, 1);
        check_eq("single_valid", out_valid, 1);
        check_eq("single_word0", out_word, 32'h33221100);
        wait_idle(0);
        check_eq("halt_after_send", halt_cores, 1);

        // new_job in IDLE clears halt; collision with capture keeps it
        new_job = 1'b1; step(); new_job = 1'b0;
        check_eq("halt_cleared", halt_cores, 0);
        core_valid = 4'b0010;
        new_job = 1'b1;
        capture(1);
        new_job = 1'b0;
        check_eq("halt_collision", halt_cores, 1);
        wait_idle(0);

        // Backpressure; new_job mid-SEND must not abort
        core_valid = 4'b0001;
        capture(0);
        new_job = 1'b1; step(); new_job = 1'b0;
        check_eq("no_abort_busy", busy, 1);
        wait_idle(1);
        check_eq("bp_drained", sb.size(), 0);

        // Core 1 pends during core 0's SEND
        core_valid = 4'b0001;
        capture(0);
        step(); step();
        core_valid[1] = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            if (core_ack != 0) ack_seen = 1'b1;
            step();
        end
        if (busy) check_eq("pend_timeout", busy, 0);
        check_eq("pend_no_early_ack", ack_seen, 0);
        capture(1);
        wait_idle(0);

        // Reset after word 4 accepted
        core_valid = 4'b1000;
        capture(3);
        base = acc_cnt;
        for (int i = 0; i < 60; i++) begin
            if (acc_cnt - base >= 5) break;
            step();
        end
        check_eq("rst_mid_accepts", acc_cnt - base, 5);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ack",   core_ack, 0);
        check_eq("mid_rst_halt",  halt_cores, 0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_last",  out_last, 0);
        check_eq("mid_rst_busy",  busy, 0);
        check_eq("mid_rst_word",  out_word, 0);
        sb.delete();
        step();
        rst = 1'b0;

        // Round-robin from fresh reset: 0, 3, 0, then 1, 2
        core_valid = 4'b1001;
        capture(0);
        check_eq("post_rst_word0", out_word, 64'(sw32(core_hash[0][255:224])));
        wait_idle(0);
        core_valid[0] = 1'b1;
        capture(3);
        wait_idle(0);
        capture(0);
        wait_idle(0);
        core_valid = 4'b0110;
        capture(1);
        wait_idle(0);
        capture(2);
        wait_idle(0);

        check_eq("sb_final_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hm_result_scheduler.md
# hm_result_scheduler

Collects valid results from up to NUM_CORES hashing cores and grants one at a time with a round-robin arbiter. Latches the winner's 256-bit hash and 32-bit nonce, then streams them to the host-side output FIFO as nine byte-swapped 32-bit words over a valid/ready handshake. Raises a halt to all cores once a result is captured; the halt holds until the job controller starts a new job. Sits between the hashing-module array and the host interface.

## Interface
Parameters:
- NUM_CORES, 4: number of hashing cores arbitrated (2–8).
- WORDS, 9: output words per result (8 hash + 1 nonce); fixed, not overridable.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_valid  in  NUM_CORES  core i holds a valid hash/nonce; held until acked.
- core_hash  in  NUM_CORES×256  per-core hash, bit 255 = MSB.
- core_nonce  in  NUM_CORES×32  per-core nonce.
- core_ack  out  NUM_CORES  one-hot, one-cycle pulse to the captured core.
- new_job  in  1  one-cycle pulse from the job controller; clears halt_cores.
- halt_cores  out  1  level; stop all cores searching.
- out_word  out  32  current output word, byte-swapped.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- out_last  out  1  high with the final (nonce) word.
- busy  out  1  high in SEND.

## Operation
- States: IDLE, SEND.
- IDLE: if any core_valid, the arbiter picks a winner. On the edge, {core_hash[w], core_nonce[w]} goes into a 288-bit result register, word index goes to 0, halt_cores is set, core_ack[w] pulses next cycle, and the state moves to SEND.
- Arbitration is round-robin. Priority starts at the index after the last grant and wraps at NUM_CORES−1 → 0. After reset, core 0 has highest priority.
- SEND: out_valid = 1. out_word = byte_swap(result[287−32k −: 32]) for word index k. Word 0 = hash[255:224], word 7 = hash[31:0], word 8 = nonce.
- On acceptance, k increments. When accepted at k = 8 (out_last = 1), the state returns to IDLE.
- out_word and out_last stay stable while out_valid && !out_ready.
- core_valid is ignored in SEND. Non-granted cores stay pending and are not acked.
- halt_cores:
  - set on capture;
  - cleared on a new_job pulse;
  - if capture and new_job fall on the same edge, capture wins and halt stays set.
- new_job does not abort an in-progress SEND.
- byte_swap(x) = {x[7:0], x[15:8], x[23:16], x[31:24]}.

## Timing
- Reset values: state = IDLE, k = 0, RR pointer → core 0. All outputs are 0: core_ack, halt_cores, out_valid, out_last, busy, out_word.
- Reset mid-SEND aborts immediately and drops the result. No ack is reissued.
- Latency: core_valid high in cycle t (IDLE). core_ack, busy, out_valid and word 0 are all present in cycle t+1.
- Back-to-back with out_ready held high: 9 cycles of out_valid, then IDLE for ≥1 cycle before the next capture. Minimum 10 cycles per result.
- A core must drop core_valid the cycle after core_ack. A core_valid still high one cycle after IDLE re-entry is treated as a new result.
- Everything is registered except out_word, which is a mux of the result register and k.

## Structure
- Package hm_pkg holds:
  - typedef enum {IDLE, SEND} hm_sched_state_t;
  - localparam HM_RESULT_WORDS = 9;
  - localparam HM_RESULT_BITS = 288;
  - function byte_swap32.
- Sub-module rr_arbiter (#NUM_CORES): req in; grant one-hot out; update strobe advances the pointer past the granted index.

## Test plan
- Single core: core 2 valid, hash = 256'h0011…EEFF pattern, nonce = 32'h12345678, out_ready = 1. Expect core_ack = 4'b0100 at t+1 and nine words, the first byte_swap(hash[255:224]). Last word = 32'h78563412 with out_last = 1. halt_cores = 1 afterwards.
- Round-robin: cores 0 and 3 valid together, hold re-asserted. Expect grant order 0, 3, 0. With cores 1 and 2 valid after granting 1, expect 2 next.
- Backpressure: toggle out_ready 1,0,0,1… Expect out_word/out_last stable during stalls and exactly 9 accepted words, in order.
- Halt/new_job collision: new_job pulse on the capture edge → halt stays 1. A later new_job in IDLE → halt = 0 next cycle.
- Reset mid-SEND: assert rst after word 4 is accepted. Expect all outputs 0 immediately and state IDLE. The next capture starts at word 0 with core 0 priority.
- Pending core during SEND: core 1 raises core_valid while core 0's result is streaming. Expect no ack until SEND ends, then a capture on the first IDLE cycle.
